// File: rtl/key_step_ctrl_if.sv
// key_step_ctrl_if: bundles the raw push-key inputs and the adjusted-value
// outputs of key_step_ctrl.
//   key_add/key_sub : raw active-low keys, asynchronous to the consumer clock
//   value/step_pulse/step_dir/at_limit : adjusted value and change indicators
// The master modport drives the keys and observes the results; the slave
// modport is the controller side.
interface key_step_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             key_add;
  logic             key_sub;
  logic [WIDTH-1:0] value;
  logic             step_pulse;
  logic             step_dir;
  logic             at_limit;

  modport master (
    output key_add,
    output key_sub,
    input  value,
    input  step_pulse,
    input  step_dir,
    input  at_limit
  );

  modport slave (
    input  key_add,
    input  key_sub,
    output value,
    output step_pulse,
    output step_dir,
    output at_limit
  );
endinterface

// File: rtl/key_step_ctrl.sv
// key_step_ctrl: turns two debounced active-low push-keys (up/down) into
// bounded STEP adjustments of a WIDTH-bit value, with one step per press,
// optional hold-to-auto-repeat, saturate-or-wrap bounds and a both-keys lockout.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : key_step_ctrl_if.slave -- key_add/key_sub in (raw, async, active-low);
//          value, step_pulse, step_dir, at_limit out (all registered)
// Latency: first step lands DEBOUNCE_CYC+3 edges after the first edge that
// samples a key low (2 sync flops, DEBOUNCE_CYC debounce edges, 1 FSM edge).
module key_step_ctrl #(
  parameter int WIDTH        = 10,
  parameter int STEP         = 5,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 1023,
  parameter int INIT_VAL     = 0,
  parameter int DEBOUNCE_CYC = 135000,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_CYC     = 13500000,
  parameter int REPEAT_CYC   = 2700000,
  parameter int WRAP         = 0
) (
  input logic             clk,
  input logic             rst,
  key_step_ctrl_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // Debounce counter only needs to reach DEBOUNCE_CYC-1.
  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  // One counter is shared between the hold and repeat phases.
  localparam int HR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HR_W   = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HR_W-1:0] HOLD_LAST = HR_W'(HOLD_CYC - 1);
  localparam logic [HR_W-1:0] REP_LAST  = HR_W'(REPEAT_CYC - 1);

  // One extra bit so value+STEP can never overflow before the bound test.
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);

  localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic             INIT_LIM = (INIT_VAL == MIN_VAL) || (INIT_VAL == MAX_VAL);

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer; index 0 = add key, index 1 = sub key.
  // All levels are active-low: 1 means released.
  // ---------------------------------------------------------------------------
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      deb;
  logic [DB_W-1:0] db_cnt_add;
  logic [DB_W-1:0] db_cnt_sub;

  assign raw = {bus.key_sub, bus.key_add};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      deb        <= 2'b11;
      db_cnt_add <= '0;
      db_cnt_sub <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;

      // A level change is accepted only after DEBOUNCE_CYC consecutive
      // mismatching edges; any return to the old level restarts the count.
      if (sync2[0] == deb[0]) begin
        db_cnt_add <= '0;
      end else if (db_cnt_add == DB_LAST) begin
        deb[0]     <= sync2[0];
        db_cnt_add <= '0;
      end else begin
        db_cnt_add <= db_cnt_add + 1'b1;
      end

      if (sync2[1] == deb[1]) begin
        db_cnt_sub <= '0;
      end else if (db_cnt_sub == DB_LAST) begin
        deb[1]     <= sync2[1];
        db_cnt_sub <= '0;
      end else begin
        db_cnt_sub <= db_cnt_sub + 1'b1;
      end
    end
  end

  logic add_on;
  logic sub_on;

  assign add_on = ~deb[0];
  assign sub_on = ~deb[1];

  // ---------------------------------------------------------------------------
  // Press FSM state
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  state_t           state;
  logic             dir_q;      // key that started the press: 1 = add
  logic [HR_W-1:0]  hr_cnt;
  logic [WIDTH-1:0] value_q;
  logic             pulse_q;
  logic             sdir_q;
  logic             lim_q;

  // Active key is the one that started the press; the other one only matters
  // as a lockout trigger.
  logic act_on;
  logic oth_on;

  assign act_on = dir_q ? add_on : sub_on;
  assign oth_on = dir_q ? sub_on : add_on;

  // ---------------------------------------------------------------------------
  // Step request: mirrors the FSM transitions that carry a step.
  // ---------------------------------------------------------------------------
  logic step_req;
  logic step_up;

  always_comb begin
    step_req = 1'b0;
    step_up  = 1'b0;
    case (state)
      IDLE: begin
        if (add_on ^ sub_on) begin
          step_req = 1'b1;
          step_up  = add_on;
        end
      end
      HOLD: begin
        if (act_on && !oth_on && (REPEAT_EN != 0) && (hr_cnt == HOLD_LAST)) begin
          step_req = 1'b1;
          step_up  = dir_q;
        end
      end
      REPEAT: begin
        if (act_on && !oth_on && (hr_cnt == REP_LAST)) begin
          step_req = 1'b1;
          step_up  = dir_q;
        end
      end
      default: begin
        step_req = 1'b0;
        step_up  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bounded arithmetic in WIDTH+1 bits. STEP never exceeds the range, so a
  // single wrap correction is always enough.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   val_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   up_val;
  logic [WIDTH:0]   dn_val;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] nxt_val;

  always_comb begin
    val_x  = {1'b0, value_q};
    up_sum = val_x + STEP_X;

    if (up_sum > MAX_X) begin
      if (WRAP != 0) begin
        up_val = MIN_X + (up_sum - MAX_X - ONE_X);
      end else begin
        up_val = MAX_X;
      end
    end else begin
      up_val = up_sum;
    end

    // value-STEP < MIN rewritten as value < MIN+STEP to stay unsigned.
    if (val_x < (MIN_X + STEP_X)) begin
      if (WRAP != 0) begin
        dn_val = MAX_X - (MIN_X + STEP_X - val_x - ONE_X);
      end else begin
        dn_val = MIN_X;
      end
    end else begin
      dn_val = val_x - STEP_X;
    end

    new_val = step_up ? up_val[WIDTH-1:0] : dn_val[WIDTH-1:0];
    nxt_val = step_req ? new_val : value_q;
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      hr_cnt  <= '0;
      value_q <= INIT_V;
      pulse_q <= 1'b0;
      sdir_q  <= 1'b0;
      lim_q   <= INIT_LIM;
    end else begin
      // A step that lands on an already-saturated bound is silent, but the
      // FSM still advances exactly as if it had moved.
      if (step_req && (new_val != value_q)) begin
        value_q <= new_val;
        pulse_q <= 1'b1;
        sdir_q  <= step_up;
      end else begin
        pulse_q <= 1'b0;
      end

      // Derived from the next value so it lines up with value.
      lim_q <= (nxt_val == MIN_V) || (nxt_val == MAX_V);

      case (state)
        IDLE: begin
          if (add_on && sub_on) begin
            state <= LOCK;
          end else if (add_on || sub_on) begin
            state  <= HOLD;
            dir_q  <= add_on;
            hr_cnt <= '0;
          end
        end
        HOLD: begin
          if (!act_on) begin
            state <= IDLE;
          end else if (oth_on) begin
            state <= LOCK;
          end else if (REPEAT_EN != 0) begin
            if (hr_cnt == HOLD_LAST) begin
              state  <= REPEAT;
              hr_cnt <= '0;
            end else begin
              hr_cnt <= hr_cnt + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (!act_on) begin
            state <= IDLE;
          end else if (oth_on) begin
            state <= LOCK;
          end else if (hr_cnt == REP_LAST) begin
            hr_cnt <= '0;
          end else begin
            hr_cnt <= hr_cnt + 1'b1;
          end
        end
        LOCK: begin
          // Leave only once both keys are released, so letting go of one
          // key of a pair never produces a step.
          if (!add_on && !sub_on) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.value      = value_q;
  assign bus.step_pulse = pulse_q;
  assign bus.step_dir   = sdir_q;
  assign bus.at_limit   = lim_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb_key_step_ctrl: directed bench for key_step_ctrl using a saturating and a
// wrapping instance with short debounce/hold/repeat timings.
// Ports: none (top level); clock and reset generated locally.
module tb_key_step_ctrl;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  key_step_ctrl_if #(.WIDTH(W)) sat_if ();
  key_step_ctrl_if #(.WIDTH(W)) wrp_if ();

  key_step_ctrl #(
    .WIDTH(W), .STEP(5), .MIN_VAL(0), .MAX_VAL(20), .INIT_VAL(0),
    .DEBOUNCE_CYC(4), .REPEAT_EN(1), .HOLD_CYC(20), .REPEAT_CYC(5), .WRAP(0)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_if.slave)
  );

  key_step_ctrl #(
    .WIDTH(W), .STEP(5), .MIN_VAL(0), .MAX_VAL(20), .INIT_VAL(0),
    .DEBOUNCE_CYC(4), .REPEAT_EN(1), .HOLD_CYC(20), .REPEAT_CYC(5), .WRAP(1)
  ) u_wrp (
    .clk (clk),
    .rst (rst),
    .bus (wrp_if.slave)
  );

  int total  = 0;
  int bad    = 0;
  int pc_sat = 0;
  int pc_wrp = 0;

  typedef struct {
    logic add;
    logic sub;
    int   cyc;
    int   exp_val;
    int   exp_pulses;
    int   exp_dir;
    int   exp_lim;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and count change pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sat_if.step_pulse) pc_sat++;
    if (wrp_if.step_pulse) pc_wrp++;
  endtask

  // One short press on the wrapping instance (well below the hold time).
  task automatic press_wrp(input logic up);
    if (up) wrp_if.key_add = 1'b0;
    else    wrp_if.key_sub = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    wrp_if.key_add = 1'b1;
    wrp_if.key_sub = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  initial begin
    // key levels:            add   sub  cyc val pulses dir lim
    vecs[0]  = '{1'b1, 1'b0,  3,  5, 0, 1, 0};  // 3-cycle glitch on sub
    vecs[1]  = '{1'b1, 1'b1, 12,  5, 0, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 10,  0, 1, 0, 1};  // sub press 5 -> 0
    vecs[3]  = '{1'b1, 1'b1, 12,  0, 0, 0, 1};
    vecs[4]  = '{1'b1, 1'b0, 10,  0, 0, 0, 1};  // sub at MIN: silent
    vecs[5]  = '{1'b1, 1'b1, 12,  0, 0, 0, 1};
    vecs[6]  = '{1'b0, 1'b1, 10,  5, 1, 1, 0};  // add press, stays held
    vecs[7]  = '{1'b0, 1'b0, 10,  5, 0, 1, 0};  // sub joins -> lockout
    vecs[8]  = '{1'b0, 1'b1, 30,  5, 0, 1, 0};  // sub released, add held
    vecs[9]  = '{1'b1, 1'b1, 12,  5, 0, 1, 0};  // both released
    vecs[10] = '{1'b0, 1'b1, 10, 10, 1, 1, 0};  // stepping resumes
    vecs[11] = '{1'b1, 1'b1, 12, 10, 0, 1, 0};

    sat_if.key_add = 1'b1;
    sat_if.key_sub = 1'b1;
    wrp_if.key_add = 1'b1;
    wrp_if.key_sub = 1'b1;

    // Reset state
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_value", int'(sat_if.value), 0);
    check("rst_at_limit", int'(sat_if.at_limit), 1);
    check("rst_step_pulse", int'(sat_if.step_pulse), 0);
    check("rst_step_dir", int'(sat_if.step_dir), 0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) tick();

    // First step: exact latency of DEBOUNCE_CYC+3 = 7 edges
    pc_sat = 0;
    for (int e = 1; e <= 25; e++) begin
      sat_if.key_add = (e <= 10) ? 1'b0 : 1'b1;
      tick();
      if (e == 6) check("first_e6_value", int'(sat_if.value), 0);
      if (e == 7) begin
        check("first_e7_value", int'(sat_if.value), 5);
        check("first_e7_pulse", int'(sat_if.step_pulse), 1);
      end
    end
    check("first_pulses", pc_sat, 1);
    check("first_dir", int'(sat_if.step_dir), 1);

    // Table: glitch, saturation at MIN, lockout
    for (int i = 0; i < 12; i++) begin
      pc_sat = 0;
      sat_if.key_add = vecs[i].add;
      sat_if.key_sub = vecs[i].sub;
      for (int c = 0; c < vecs[i].cyc; c++) tick();
      check($sformatf("vec%0d_value", i), int'(sat_if.value), vecs[i].exp_val);
      check($sformatf("vec%0d_pulses", i), pc_sat, vecs[i].exp_pulses);
      check($sformatf("vec%0d_dir", i), int'(sat_if.step_dir), vecs[i].exp_dir);
      check($sformatf("vec%0d_at_limit", i), int'(sat_if.at_limit), vecs[i].exp_lim);
    end

    // Auto-repeat and saturation at MAX from value 0
    rst = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    check("rep_rst_value", int'(sat_if.value), 0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    pc_sat = 0;
    sat_if.key_add = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (e == 6)  check("rep_e6_value", int'(sat_if.value), 0);
      if (e == 7)  check("rep_e7_pulse", int'(sat_if.step_pulse), 1);
      if (e == 26) check("rep_e26_value", int'(sat_if.value), 5);
      if (e == 27) begin
        check("rep_e27_value", int'(sat_if.value), 10);
        check("rep_e27_pulse", int'(sat_if.step_pulse), 1);
      end
      if (e == 31) check("rep_e31_value", int'(sat_if.value), 10);
      if (e == 32) check("rep_e32_value", int'(sat_if.value), 15);
      if (e == 37) begin
        check("rep_e37_value", int'(sat_if.value), 20);
        check("rep_e37_at_limit", int'(sat_if.at_limit), 1);
      end
    end
    check("rep_pulses", pc_sat, 4);
    check("rep_final_value", int'(sat_if.value), 20);
    check("rep_final_at_limit", int'(sat_if.at_limit), 1);

    // Reset while still repeating with the key held
    rst = 1'b0;
    tick();
    check("midrst_value", int'(sat_if.value), 0);
    check("midrst_at_limit", int'(sat_if.at_limit), 1);
    check("midrst_pulse", int'(sat_if.step_pulse), 0);
    check("midrst_dir", int'(sat_if.step_dir), 0);
    tick();
    rst = 1'b1;
    pc_sat = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) check("midrst_e6_value", int'(sat_if.value), 0);
      if (e == 7) begin
        check("midrst_e7_value", int'(sat_if.value), 5);
        check("midrst_e7_pulse", int'(sat_if.step_pulse), 1);
      end
    end
    check("midrst_pulses", pc_sat, 1);
    sat_if.key_add = 1'b1;
    for (int i = 0; i < 15; i++) tick();

    // Wrap instance: 0 -> 20 in four presses, then 20 + 5 wraps to 4
    for (int p = 0; p < 4; p++) press_wrp(1'b1);
    check("wrap_at_max_value", int'(wrp_if.value), 20);
    check("wrap_at_max_limit", int'(wrp_if.at_limit), 1);
    pc_wrp = 0;
    press_wrp(1'b1);
    check("wrap_up_value", int'(wrp_if.value), 4);
    check("wrap_up_pulses", pc_wrp, 1);
    check("wrap_up_dir", int'(wrp_if.step_dir), 1);
    check("wrap_up_at_limit", int'(wrp_if.at_limit), 0);

    // 0 - 5 wraps to 16
    rst = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    check("wrap_rst_value", int'(wrp_if.value), 0);
    pc_wrp = 0;
    press_wrp(1'b0);
    check("wrap_dn_value", int'(wrp_if.value), 16);
    check("wrap_dn_pulses", pc_wrp, 1);
    check("wrap_dn_dir", int'(wrp_if.step_dir), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
